gray_stream_tx: RTL and testbench
=================================

GRAY_STREAM_TX -- requirements
Module: gray_stream_tx

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 320, pixels per row.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 240, rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, frame-memory address width; must satisfy 2^ADDR_W >= IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-004 SHALL have parameter GAP_W, default 4, width of the gap_cycles input.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock); rst_n (input, 1, async active-low reset).
REQ-006 SHALL have start (input, 1): a one-cycle pulse that requests a frame.
REQ-007 SHALL have gap_cycles (input, GAP_W): idle cycles between pixels; sampled only on an accepted start.
REQ-008 SHALL have mem_rd_en (output, 1) and mem_addr (output, ADDR_W): synchronous-RAM read request.
REQ-009 SHALL have mem_rdata (input, 8): read data, valid exactly 1 cycle after mem_rd_en.
REQ-010 SHALL have gray_valid (output, 1) and gray (output, 8): the pixel stream consumed by the mean/filter blocks.
REQ-011 SHALL have pix_row (output, 16) and pix_col (output, 16): coordinates of the pixel qualified by gray_valid.
REQ-012 SHALL have busy (output, 1), high while a frame is in flight, and frame_done (output, 1), a one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN SHALL occur on start=1; while not in IDLE, start SHALL be ignored.
REQ-015 In RUN, the block SHALL issue one mem_rd_en every (gap_cycles+1) cycles, with addresses 0,1,...,W*H-1 in raster order; the first read SHALL occur the cycle after start.
REQ-016 Each read SHALL produce gray_valid=1 exactly 2 cycles after its mem_rd_en, with gray equal to mem_rdata registered once; the pipeline SHALL be fully pipelined, so gap_cycles=0 gives one pixel per clock.
REQ-017 pix_col SHALL wrap from IMAGE_WIDTH-1 to 0, at which point pix_row SHALL increment; both SHALL align with gray_valid.
REQ-018 After the read of address W*H-1, the FSM SHALL go RUN->DRAIN; DRAIN->DONE SHALL occur on the cycle the last gray_valid is driven.
REQ-019 DONE SHALL last one cycle with frame_done=1, then return to IDLE.
REQ-020 busy SHALL be 1 from the cycle after an accepted start through the DONE cycle inclusive.
REQ-021 gray_valid SHALL be 0 in IDLE and DONE; gray, pix_row and pix_col SHALL hold their last values when gray_valid=0.
REQ-022 The latched gap value SHALL be constant for the whole frame; changes on gap_cycles mid-frame SHALL have no effect.
REQ-023 Exactly W*H gray_valid pulses SHALL occur per frame, with no duplicates and no skips.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state IDLE; mem_rd_en, gray_valid, busy and frame_done to 0; mem_addr, gray, pix_row, pix_col and the gap latch to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no frame_done; in-flight reads SHALL be discarded.
REQ-026 After rst_n deassertion, the block SHALL accept start on the first clock edge.

Configuration
REQ-027 Macro GRAY_TX_CHECKSUM_EN defined: the block SHALL add output frame_sum (32), cleared on accepted start, accumulating gray on every gray_valid, and stable from frame_done until the next start.
REQ-028 Macro GRAY_TX_CHECKSUM_EN undefined: the frame_sum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover: W=8, H=4, gap=0, RAM[a]=a[7:0], start at cycle 0 -> first gray_valid at cycle 3, 32 consecutive pulses, gray=0..31, frame_done at cycle 35.
REQ-030 The bench SHALL cover: gap=3, same frame -> gray_valid every 4 cycles; pix_col 7->0 wraps with pix_row incrementing; 32 pulses total.
REQ-031 The bench SHALL cover: start re-pulsed at cycle 10 mid-frame -> ignored; exactly one frame_done; pixel count 32.
REQ-032 The bench SHALL cover: rst_n low at cycle 15 -> busy=0 and gray_valid=0 immediately; no frame_done; a new start gives a full frame from address 0.
REQ-033 The bench SHALL cover: with GRAY_TX_CHECKSUM_EN, RAM[a]=a -> frame_sum=496 at frame_done; a second frame restarts from 0 and again ends at 496.
REQ-034 The bench SHALL cover: W=320, H=240, file-loaded image, gap=10 -> 76800 pulses, and the captured stream SHALL match the source PGM bit-exactly.

Source files
------------

// File: rtl/gray_stream_tx.sv
// gray_stream_tx -- streams one grayscale frame out of a synchronous frame RAM.
//
// A start pulse in IDLE begins a frame. The block reads addresses 0..W*H-1 in
// raster order, one read every (gap_cycles+1) cycles. Each pixel leaves on
// gray/gray_valid two cycles after its read, together with its row/column.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle frame request (ignored unless IDLE)
//   gap_cycles         idle cycles between reads, latched on accepted start
//   mem_rd_en/addr     read request to the frame RAM (1-cycle read latency)
//   mem_rdata          RAM read data
//   gray_valid/gray    pixel stream
//   pix_row/pix_col    coordinates of the pixel qualified by gray_valid
//   busy               frame in flight (RUN, DRAIN, DONE)
//   frame_done         one-cycle completion pulse
//   frame_sum          (only with GRAY_TX_CHECKSUM_EN) sum of the frame's pixels
//
// Optional feature macro: GRAY_TX_CHECKSUM_EN.
module gray_stream_tx #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int ADDR_W       = 17,
  parameter int GAP_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              gray_valid,
  output logic [7:0]        gray,
  output logic [15:0]       pix_row,
  output logic [15:0]       pix_col,
  output logic              busy,
  output logic              frame_done
`ifdef GRAY_TX_CHECKSUM_EN
  ,
  output logic [31:0]       frame_sum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_WIDTH*IMAGE_HEIGHT-1);
  localparam logic [15:0]       LAST_COL  = 16'(IMAGE_WIDTH-1);
  localparam logic [15:0]       LAST_ROW  = 16'(IMAGE_HEIGHT-1);
  localparam int                STAGES    = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [GAP_W-1:0]   gap_q, gap_cnt;
  // vld_pipe[0]: mem_rdata valid this cycle; vld_pipe[STAGES]: gray_valid
  logic [STAGES:0]    vld_pipe;
  logic [15:0]        nxt_row, nxt_col;
  logic               accept, last_rd, last_pix;

  assign accept   = (state == IDLE) && start;
  assign last_rd  = (state == RUN) && mem_rd_en && (mem_addr == LAST_ADDR);
  assign last_pix = gray_valid && (pix_col == LAST_COL) && (pix_row == LAST_ROW);

  assign gray_valid = vld_pipe[STAGES];
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_rd)  state_nxt = DRAIN;
      DRAIN:   if (last_pix) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Read issue. gap_cnt is loaded with the gap on every read and counts down;
  // a read is launched from the cycle it reads zero, giving a gap+1 period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      if (accept) begin
        mem_rd_en <= 1'b1;
        mem_addr  <= '0;
        gap_q     <= gap_cycles;
        gap_cnt   <= gap_cycles;
      end else if ((state == RUN) && !last_rd) begin
        if (gap_cnt == '0) begin
          mem_rd_en <= 1'b1;
          mem_addr  <= mem_addr + 1'b1;
          gap_cnt   <= gap_q;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
    end
  end

  // Return path: register rdata once; coordinates come from a shadow
  // counter so the first pixel of a frame reports (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      gray     <= '0;
      pix_row  <= '0;
      pix_col  <= '0;
      nxt_row  <= '0;
      nxt_col  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], mem_rd_en};
      if (accept) begin
        nxt_row <= '0;
        nxt_col <= '0;
      end else if (vld_pipe[0]) begin
        gray    <= mem_rdata;
        pix_row <= nxt_row;
        pix_col <= nxt_col;
        if (nxt_col == LAST_COL) begin
          nxt_col <= '0;
          nxt_row <= nxt_row + 16'd1;
        end else begin
          nxt_col <= nxt_col + 16'd1;
        end
      end
    end
  end

`ifdef GRAY_TX_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_sum <= '0;
    else if (accept)     frame_sum <= '0;
    else if (gray_valid) frame_sum <= frame_sum + {24'd0, gray};
  end
`endif

endmodule

// File: tb/tb_gray_stream_tx.sv
// Directed bench for gray_stream_tx on an 8x4 frame with RAM[a] = a.
// Cycle 0 is the cycle in which start is high; outputs are sampled on the
// falling edge of each cycle.
module tb_gray_stream_tx;
  localparam int W = 8, H = 4, AW = 5, GW = 4;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [GW-1:0] gap_cycles = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = '0;
  logic          gray_valid, busy, frame_done;
  logic [7:0]    gray;
  logic [15:0]   pix_row, pix_col;
`ifdef GRAY_TX_CHECKSUM_EN
  logic [31:0]   frame_sum;
`endif

  int n_chk = 0, n_fail = 0;

  gray_stream_tx #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(AW), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gap_cycles(gap_cycles),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .gray_valid(gray_valid), .gray(gray), .pix_row(pix_row), .pix_col(pix_col),
    .busy(busy), .frame_done(frame_done)
`ifdef GRAY_TX_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  always #5 clk = ~clk;

  // synchronous RAM, one cycle read latency, content = address
  always @(posedge clk) if (mem_rd_en) mem_rdata <= 8'(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge.
  // restart_cyc: cycle to re-pulse start; rst_cyc: cycle to assert reset;
  // gap_chg_cyc/gap_chg: mid-frame change of gap_cycles (-1 disables).
  task automatic run_frame(input int g, input int restart_cyc, input int rst_cyc,
                           input int gap_chg_cyc, input int gap_chg,
                           output int npix, output int ndone, output int done_cyc);
    int stop;
    npix = 0; ndone = 0; done_cyc = -1; stop = 400;
    gap_cycles = GW'(g);
    for (int cyc = 0; cyc < stop; cyc++) begin
      start = (cyc == 0) || (cyc == restart_cyc);
      if (cyc == gap_chg_cyc) gap_cycles = GW'(gap_chg);
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gv", 32'(gray_valid), 32'd0);
        chk("rst_rd", 32'(mem_rd_en), 32'd0);
        stop = cyc + 6;
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 3) rst_n = 1'b1;
      if (cyc == 0) chk("busy_c0", 32'(busy), 32'd0);
      if (cyc == 1) begin
        chk("rd_c1", 32'(mem_rd_en), 32'd1);
        chk("addr_c1", 32'(mem_addr), 32'd0);
        chk("busy_c1", 32'(busy), 32'd1);
      end
      if (gray_valid) begin
        chk("gray", 32'(gray), 32'(npix % 256));
        chk("col", 32'(pix_col), 32'(npix % W));
        chk("row", 32'(pix_row), 32'(npix / W));
        chk("gv_cycle", 32'(cyc), 32'(3 + npix * (g + 1)));
        npix++;
      end
      if (frame_done) begin
        ndone++;
        done_cyc = cyc;
        chk("busy_done", 32'(busy), 32'd1);
        chk("gv_done", 32'(gray_valid), 32'd0);
`ifdef GRAY_TX_CHECKSUM_EN
        chk("frame_sum", frame_sum, 32'd496);
`endif
        stop = cyc + 3;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_1cyc", 32'(frame_done), 32'd0);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int np, nd, dc;
    repeat (3) @(negedge clk);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(frame_done), 32'd0);
    chk("rst_gv0", 32'(gray_valid), 32'd0);
    chk("rst_rd0", 32'(mem_rd_en), 32'd0);
    chk("rst_addr0", 32'(mem_addr), 32'd0);
    chk("rst_gray0", 32'(gray), 32'd0);
    chk("rst_row0", 32'(pix_row), 32'd0);
    chk("rst_col0", 32'(pix_col), 32'd0);

    // start on the very first edge after reset release, gap 0
    rst_n = 1'b1;
    run_frame(0, -1, -1, -1, 0, np, nd, dc);
    chk("f1_pix", 32'(np), 32'd32);
    chk("f1_ndone", 32'(nd), 32'd1);
    chk("f1_done_cyc", 32'(dc), 32'd35);
    chk("hold_gray", 32'(gray), 32'd31);
    chk("hold_col", 32'(pix_col), 32'd7);
    chk("hold_row", 32'(pix_row), 32'd3);
    chk("hold_gv", 32'(gray_valid), 32'd0);

    // gap 3, input changed to 0 mid-frame must not matter
    run_frame(3, -1, -1, 6, 0, np, nd, dc);
    chk("f2_pix", 32'(np), 32'd32);
    chk("f2_ndone", 32'(nd), 32'd1);
    chk("f2_done_cyc", 32'(dc), 32'd128);

    // start re-pulsed at cycle 10 is ignored
    run_frame(0, 10, -1, -1, 0, np, nd, dc);
    chk("f3_pix", 32'(np), 32'd32);
    chk("f3_ndone", 32'(nd), 32'd1);
    chk("f3_done_cyc", 32'(dc), 32'd35);

    // reset at cycle 15 aborts: 12 pixels (cycles 3..14), no frame_done
    run_frame(0, -1, 15, -1, 0, np, nd, dc);
    chk("f4_pix", 32'(np), 32'd12);
    chk("f4_ndone", 32'(nd), 32'd0);

    // full frame again from address 0
    run_frame(0, -1, -1, -1, 0, np, nd, dc);
    chk("f5_pix", 32'(np), 32'd32);
    chk("f5_ndone", 32'(nd), 32'd1);
    chk("f5_done_cyc", 32'(dc), 32'd35);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
